// File: rtl/ex_stage.sv
// Execute stage: combinational ALU/shift/compare/multiply, effective-address adder,
// and an iterative radix-2 restoring divider that holds the pipeline until its result is ready.
package ex_stage_pkg;
   localparam int DATA_WIDTH   = 32;
   localparam int REG_WIDTH    = 5;
   localparam int ALU_OP_WIDTH = 5;

   localparam logic [ALU_OP_WIDTH-1:0] ALU_NOP    = 5'd0;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD    = 5'd1;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB    = 5'd2;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL    = 5'd3;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL    = 5'd4;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA    = 5'd5;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT    = 5'd6;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU   = 5'd7;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR    = 5'd8;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OR     = 5'd9;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_AND    = 5'd10;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_LUI    = 5'd11;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_JAL    = 5'd12;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_MUL    = 5'd13;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_MULH   = 5'd14;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_MULHSU = 5'd15;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_MULHU  = 5'd16;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV    = 5'd17;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU   = 5'd18;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_REM    = 5'd19;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU   = 5'd20;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_LB     = 5'd21;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_LH     = 5'd22;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_LW     = 5'd23;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_LBU    = 5'd24;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_LHU    = 5'd25;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SB     = 5'd26;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SH     = 5'd27;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SW     = 5'd28;
endpackage

// state | meaning
// IDLE  | no divide in flight; special-case divides resolve combinationally
// BUSY  | one restoring step per cycle, 32 steps
// DONE  | signed quotient/remainder latched and driven until stall[3] drops
module ex_stage
   import ex_stage_pkg::*;
(
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [5:0]              stall,
   input  logic [ALU_OP_WIDTH-1:0] aluop_i,
   input  logic [DATA_WIDTH-1:0]   reg1_i,
   input  logic [DATA_WIDTH-1:0]   reg2_i,
   input  logic [REG_WIDTH-1:0]    rd_i,
   input  logic                    rd_op_i,
   input  logic [DATA_WIDTH-1:0]   link_address_i,
   input  logic [DATA_WIDTH-1:0]   inst_i,
   output logic [REG_WIDTH-1:0]    wd_o,
   output logic                    wreg_o,
   output logic [DATA_WIDTH-1:0]   wdata_o,
   output logic [ALU_OP_WIDTH-1:0] aluop_o,
   output logic [DATA_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH-1:0]   reg2_o,
   output logic                    stallreq_o
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_e;

   div_state_e  state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] dvd_q, dvd_d;
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_res_q, quo_res_d;
   logic [31:0] rem_res_q, rem_res_d;
   logic        neg_q_q, neg_q_d;
   logic        neg_r_q, neg_r_d;
   logic        sel_rem_q, sel_rem_d;

   logic        is_div, is_signed, is_rem_op, div_zero, div_ovf;
   logic [31:0] abs_a, abs_b;
   logic [32:0] shifted, diff;
   logic        q_bit;
   logic [31:0] rem_step, quo_step;
   logic [31:0] div_res, alu_res;
   logic [63:0] prod_ss, prod_su, prod_uu;
   logic [11:0] imm;
   logic        unused_ok;

   assign is_div    = (aluop_i == ALU_DIV) || (aluop_i == ALU_DIVU) ||
                      (aluop_i == ALU_REM) || (aluop_i == ALU_REMU);
   assign is_signed = (aluop_i == ALU_DIV) || (aluop_i == ALU_REM);
   assign is_rem_op = (aluop_i == ALU_REM) || (aluop_i == ALU_REMU);
   assign div_zero  = (reg2_i == 32'd0);
   assign div_ovf   = is_signed && (reg1_i == 32'h8000_0000) && (reg2_i == 32'hFFFF_FFFF);
   assign abs_a     = (is_signed && reg1_i[31]) ? -reg1_i : reg1_i;
   assign abs_b     = (is_signed && reg2_i[31]) ? -reg2_i : reg2_i;

   // Partial remainder and quotient share one shift chain: dvd_q fills with quotient bits.
   assign shifted  = {rem_q, dvd_q[31]};
   assign diff     = shifted - {1'b0, dvs_q};
   assign q_bit    = ~diff[32];
   assign rem_step = q_bit ? diff[31:0] : shifted[31:0];
   assign quo_step = {dvd_q[30:0], q_bit};

   assign prod_ss = {{32{reg1_i[31]}}, reg1_i} * {{32{reg2_i[31]}}, reg2_i};
   assign prod_su = {{32{reg1_i[31]}}, reg1_i} * {32'd0, reg2_i};
   assign prod_uu = {32'd0, reg1_i} * {32'd0, reg2_i};

   always_comb begin
      alu_res = 32'd0;
      case (aluop_i)
         ALU_ADD:    alu_res = reg1_i + reg2_i;
         ALU_SUB:    alu_res = reg1_i - reg2_i;
         ALU_SLL:    alu_res = reg1_i << reg2_i[4:0];
         ALU_SRL:    alu_res = reg1_i >> reg2_i[4:0];
         ALU_SRA:    alu_res = $signed(reg1_i) >>> reg2_i[4:0];
         ALU_SLT:    alu_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
         ALU_SLTU:   alu_res = {31'd0, reg1_i < reg2_i};
         ALU_XOR:    alu_res = reg1_i ^ reg2_i;
         ALU_OR:     alu_res = reg1_i | reg2_i;
         ALU_AND:    alu_res = reg1_i & reg2_i;
         ALU_LUI:    alu_res = reg2_i;
         ALU_JAL:    alu_res = link_address_i;
         ALU_MUL:    alu_res = prod_ss[31:0];
         ALU_MULH:   alu_res = prod_ss[63:32];
         ALU_MULHSU: alu_res = prod_su[63:32];
         ALU_MULHU:  alu_res = prod_uu[63:32];
         default:    alu_res = 32'd0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         cnt_q     <= 6'd0;
         dvd_q     <= 32'd0;
         dvs_q     <= 32'd0;
         rem_q     <= 32'd0;
         quo_res_q <= 32'd0;
         rem_res_q <= 32'd0;
         neg_q_q   <= 1'b0;
         neg_r_q   <= 1'b0;
         sel_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         rem_q     <= rem_d;
         quo_res_q <= quo_res_d;
         rem_res_q <= rem_res_d;
         neg_q_q   <= neg_q_d;
         neg_r_q   <= neg_r_d;
         sel_rem_q <= sel_rem_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dvd_d      = dvd_q;
      dvs_d      = dvs_q;
      rem_d      = rem_q;
      quo_res_d  = quo_res_q;
      rem_res_d  = rem_res_q;
      neg_q_d    = neg_q_q;
      neg_r_d    = neg_r_q;
      sel_rem_d  = sel_rem_q;
      stallreq_o = 1'b0;
      div_res    = 32'd0;
      case (state_q)
         S_IDLE: begin
            if (is_div) begin
               if (div_zero) begin
                  div_res = is_rem_op ? reg1_i : 32'hFFFF_FFFF;
               end else if (div_ovf) begin
                  div_res = is_rem_op ? 32'd0 : 32'h8000_0000;
               end else begin
                  stallreq_o = 1'b1;
                  dvd_d      = abs_a;
                  dvs_d      = abs_b;
                  rem_d      = 32'd0;
                  neg_q_d    = is_signed & (reg1_i[31] ^ reg2_i[31]);
                  neg_r_d    = is_signed & reg1_i[31];
                  sel_rem_d  = is_rem_op;
                  cnt_d      = 6'd0;
                  state_d    = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            stallreq_o = 1'b1;
            dvd_d      = quo_step;
            rem_d      = rem_step;
            cnt_d      = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
               quo_res_d = neg_q_q ? -quo_step : quo_step;
               rem_res_d = neg_r_q ? -rem_step : rem_step;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            div_res = sel_rem_q ? rem_res_q : quo_res_q;
            if (!stall[3]) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Stores split their immediate around rd; everything else uses the I-type field.
   assign imm        = (inst_i[6:0] == 7'b0100011) ? {inst_i[31:25], inst_i[11:7]} : inst_i[31:20];
   assign mem_addr_o = reg1_i + {{20{imm[11]}}, imm};

   assign wdata_o = (is_div || state_q == S_DONE) ? div_res : alu_res;
   assign wreg_o  = rd_op_i & ~stallreq_o;
   assign wd_o    = rd_i;
   assign aluop_o = aluop_i;
   assign reg2_o  = reg2_i;

   assign unused_ok = ^{stall[5:4], stall[2:0], inst_i[19:12], prod_su[31:0], prod_uu[31:0]};

endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage against an arithmetic reference model, plus directed corner cases.
module tb_ex_stage;
   import ex_stage_pkg::*;

   logic        CLK = 1'b0;
   logic        RST;
   logic [5:0]  stall;
   logic [4:0]  aluop_i;
   logic [31:0] reg1_i, reg2_i, link_address_i, inst_i;
   logic [4:0]  rd_i;
   logic        rd_op_i;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
   logic [4:0]  aluop_o;
   logic [31:0] mem_addr_o, reg2_o;
   logic        stallreq_o;

   int n_vec = 0;
   int n_err = 0;

   ex_stage dut (
      .CLK(CLK), .RST(RST), .stall(stall), .aluop_i(aluop_i),
      .reg1_i(reg1_i), .reg2_i(reg2_i), .rd_i(rd_i), .rd_op_i(rd_op_i),
      .link_address_i(link_address_i), .inst_i(inst_i),
      .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .aluop_o(aluop_o),
      .mem_addr_o(mem_addr_o), .reg2_o(reg2_o), .stallreq_o(stallreq_o)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] link);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint ua = longint'({32'd0, a});
      longint ub = longint'({32'd0, b});
      int ia = a;
      int ib = b;
      logic [63:0] p;
      case (op)
         ALU_ADD:    return a + b;
         ALU_SUB:    return a - b;
         ALU_SLL:    return a << b[4:0];
         ALU_SRL:    return a >> b[4:0];
         ALU_SRA:    return ia >>> b[4:0];
         ALU_SLT:    return (ia < ib) ? 32'd1 : 32'd0;
         ALU_SLTU:   return (a < b) ? 32'd1 : 32'd0;
         ALU_XOR:    return a ^ b;
         ALU_OR:     return a | b;
         ALU_AND:    return a & b;
         ALU_LUI:    return b;
         ALU_JAL:    return link;
         ALU_MUL:    begin p = sa * sb; return p[31:0];  end
         ALU_MULH:   begin p = sa * sb; return p[63:32]; end
         ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
         ALU_MULHU:  begin p = ua * ub; return p[63:32]; end
         ALU_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return ia / ib;
         end
         ALU_REM: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return ia % ib;
         end
         ALU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         ALU_REMU:   return (b == 0) ? a : a % b;
         default:    return 32'd0;
      endcase
   endfunction

   function automatic bit takes_cycles(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      bit sgn = (op == ALU_DIV) || (op == ALU_REM);
      bit dv  = sgn || (op == ALU_DIVU) || (op == ALU_REMU);
      return dv && (b != 0) && !(sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   function automatic logic [31:0] ref_addr(input logic [31:0] a, input logic [31:0] inst);
      logic [11:0] imm12;
      if (inst[6:0] == 7'b0100011) imm12 = {inst[31:25], inst[11:7]};
      else                         imm12 = inst[31:20];
      return a + 32'(int'($signed(imm12)));
   endfunction

   // Apply one op, follow it through any divide stall, and check every output once it is final.
   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] inst, input logic [31:0] link,
                         input logic [4:0] rd, input logic rdop, output logic [31:0] res);
      int  n = 0;
      bit  bad = 0;
      aluop_i = op; reg1_i = a; reg2_i = b; inst_i = inst;
      link_address_i = link; rd_i = rd; rd_op_i = rdop;
      #1;
      if (takes_cycles(op, a, b)) begin
         while (stallreq_o === 1'b1 && n < 40) begin
            if (wreg_o !== 1'b0) bad = 1;
            n++;
            tick();
         end
         check_eq("stall_cycles", n, 33);
         check_eq("wreg_gated", {31'd0, bad}, 32'd0);
      end else begin
         check_eq("stallreq", {31'd0, stallreq_o}, 32'd0);
      end
      check_eq("wdata", wdata_o, ref_result(op, a, b, link));
      check_eq("wreg", {31'd0, wreg_o}, {31'd0, rdop});
      check_eq("wd", {27'd0, wd_o}, {27'd0, rd});
      check_eq("mem_addr", mem_addr_o, ref_addr(a, inst));
      check_eq("reg2_o", reg2_o, b);
      check_eq("aluop_o", {27'd0, aluop_o}, {27'd0, op});
      res = wdata_o;
   endtask

   function automatic logic [31:0] rand_opnd();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return $urandom_range(0, 300);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] res, a, b, inst;
      logic [4:0]  op;

      RST = 1'b1; stall = 6'd0; aluop_i = ALU_NOP; reg1_i = 0; reg2_i = 0;
      rd_i = 0; rd_op_i = 0; link_address_i = 0; inst_i = 0;
      tick(); tick();
      RST = 1'b0;
      #1;
      check_eq("rst_wdata", wdata_o, 32'd0);
      check_eq("rst_wreg", {31'd0, wreg_o}, 32'd0);
      check_eq("rst_stallreq", {31'd0, stallreq_o}, 32'd0);
      check_eq("rst_mem_addr", mem_addr_o, 32'd0);
      tick();

      run_op(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'h0, 32'h0, 5'd5, 1'b1, res);
      check_eq("add_ovf", res, 32'h8000_0000);
      tick();
      run_op(ALU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd6, 1'b1, res);
      check_eq("mulh_m1", res, 32'd0);
      tick();
      run_op(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd6, 1'b1, res);
      check_eq("mulhu_max", res, 32'hFFFF_FFFE);
      tick();
      run_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 5'd7, 1'b1, res);
      check_eq("div_m7_2", res, 32'hFFFF_FFFD);
      tick();
      run_op(ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 5'd7, 1'b1, res);
      check_eq("rem_m7_2", res, 32'hFFFF_FFFF);
      tick();
      run_op(ALU_DIVU, 32'd100, 32'd0, 32'h0, 32'h0, 5'd8, 1'b1, res);
      check_eq("divu_by0", res, 32'hFFFF_FFFF);
      tick();
      run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd8, 1'b1, res);
      check_eq("div_ovf", res, 32'h8000_0000);
      tick();

      // DONE held by an external EX/MEM stall, then released
      stall = 6'b001000;
      run_op(ALU_DIVU, 32'd100, 32'd7, 32'h0, 32'h0, 5'd9, 1'b1, res);
      check_eq("hold_done0", res, 32'd14);
      for (int k = 1; k <= 3; k++) begin
         tick();
         if (k == 3) stall = 6'd0;
         #1;
         check_eq("hold_wdata", wdata_o, 32'd14);
         check_eq("hold_stallreq", {31'd0, stallreq_o}, 32'd0);
      end
      tick();
      #1;
      check_eq("idle_after_done", {31'd0, stallreq_o}, 32'd1);
      aluop_i = ALU_NOP;
      #1;
      check_eq("nop_after_done", wdata_o, 32'd0);
      tick();

      // Reset in the middle of a divide discards it
      aluop_i = ALU_DIVU; reg1_i = 32'hDEAD_BEEF; reg2_i = 32'd5;
      for (int k = 0; k < 10; k++) tick();
      RST = 1'b1;
      tick();
      RST = 1'b0; aluop_i = ALU_NOP;
      #1;
      check_eq("rst_busy_stallreq", {31'd0, stallreq_o}, 32'd0);
      check_eq("rst_busy_wdata", wdata_o, 32'd0);
      tick();
      run_op(ALU_DIVU, 32'd9, 32'd3, 32'h0, 32'h0, 5'd10, 1'b1, res);
      check_eq("divu_9_3", res, 32'd3);
      tick();

      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 9) < 3) op = 5'(ALU_DIV + $urandom_range(0, 3));
         else                          op = 5'($urandom_range(0, 28));
         a = rand_opnd();
         b = rand_opnd();
         inst = $urandom;
         if ($urandom_range(0, 1) == 1) inst[6:0] = 7'b0100011;
         run_op(op, a, b, inst, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), res);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
